reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Parametrised circular reorder buffer for the out-of-order core. Instructions are allocated in program order at dispatch. Execution units write results back out of order, tagged by ROB index. Entries retire in order to the register file and flag register, and a mispredicted branch flushes every younger entry. The block sits between the decode/control stage and the architectural register file, replacing direct in-order writeback.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, at least 4
- DATA_W, 64, result width
- NUM_WB, 2, number of writeback ports
- TAG_W, $clog2(DEPTH), entry index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  ROB can accept a dispatch this cycle
- disp_rd  in  5  destination register
- disp_reg_write  in  1  entry writes a register at commit
- disp_set_flags  in  1  entry updates the flag register at commit
- disp_tag  out  TAG_W  index allocated to the dispatching entry (current tail)
- wb_valid  in  NUM_WB  writeback strobe per port
- wb_tag  in  NUM_WB×TAG_W  target entry
- wb_data  in  NUM_WB×DATA_W  result
- wb_flags  in  NUM_WB×4  {negative, zero, overflow, carry_out}
- wb_mispredict  in  NUM_WB  entry is a mispredicted branch
- commit_valid  out  1  head entry is complete
- commit_ready  in  1  register file accepts the commit
- commit_rd / commit_data / commit_flags  out  5 / DATA_W / 4  head entry payload
- commit_reg_write / commit_set_flags  out  1 / 1  head entry write enables (qualified by commit fire)
- flush  out  1  one-cycle pulse; upstream discards all in-flight work
- count  out  TAG_W+1  occupied entries
- empty / full  out  1 / 1  occupancy status

## Operation
- Head and tail are TAG_W+1-bit pointers; the MSB is a wrap bit. count = tail − head (modulo). empty when count==0. full when count==DEPTH.
- An entry is live when its index lies in the range [head, tail). Per-entry state: done, mispredict, rd, reg_write, set_flags, data, flags.
- Dispatch fires on disp_valid && disp_ready. It writes the entry at tail with done=0 and mispredict=0, then tail increments.
- disp_ready = !full && !flush. Dispatch and commit in the same cycle are both permitted. disp_ready does not anticipate a same-cycle commit when full.
- Writeback on port i sets done, data, flags and mispredict of entry wb_tag[i]:
  - Ignored if the entry is not live.
  - If two ports target the same tag in one cycle, the lower port index wins.
  - A writeback to the tag being dispatched in the same cycle is ignored; dispatch wins.
- commit_valid = !empty && head.done. It is combinational from head state; a writeback is not bypassed to commit in the same cycle.
- Commit fires on commit_valid && commit_ready. Head then increments, and commit_reg_write and commit_set_flags are asserted only in the fire cycle.
- Mispredict: when a firing commit has mispredict=1, the entry still commits its payload. At that edge:
  - head and tail are both set to head+1;
  - all done bits are cleared;
  - flush is registered high for the following cycle.
- During the flush cycle, any dispatch is rejected and any writeback is ignored.
- Reset (asynchronous, mid-operation included) clears head, tail, done, mispredict and flush.
- Outputs after reset: disp_ready=1, disp_tag=0, commit_valid=0, flush=0, count=0, empty=1, full=0. Payload outputs are don't-care while commit_valid=0.

## Timing
- Dispatch at edge N: the entry is live from cycle N+1, and the earliest accepted writeback is cycle N+1.
- Writeback at edge M: commit_valid can be high in cycle M+1 if the entry is at head.
- Sustained throughput is one dispatch and one commit per cycle. Up to NUM_WB writebacks are accepted per cycle.
- Mispredict commit at edge K: flush=1 and count=0 in cycle K+1, and dispatch resumes at cycle K+2.
- Pointer wrap: tag DEPTH−1 is followed by tag 0. The wrap bit toggles so that full and empty remain distinguishable.

## Structure
- rob_pkg holds:
  - rob_entry_t packed struct: done, mispredict, rd, reg_write, set_flags, data, flags;
  - flag bit-position constants;
  - FLAG_W=4 and REG_IDX_W=5.
- One sub-module, rob_ptr: a TAG_W+1-bit wrapping pointer with increment and load inputs. It is instantiated once for head and once for tail.
- The entry array is flops. The multi-port writeback uses a per-entry priority decode.

## Test plan
- Reset, then dispatch 3 entries; write back tags 2, 0, 1 in separate cycles with data 0x30, 0x10, 0x20. Commits must occur in order 0x10, 0x20, 0x30, with the first commit one cycle after tag 0 writes back.
- With DEPTH=16, dispatch 16 entries without writeback. full=1, disp_ready=0, count=16. Write back and commit one entry; on the next cycle, one dispatch is accepted and disp_tag=0 (wrap).
- Same-cycle collision: port 0 and port 1 both write tag 5 with 0xAA and 0xBB. The entry must hold 0xAA.
- Mispredict: dispatch tags 0–5, write back all with wb_mispredict on tag 2, commit_ready=1. Tags 0–2 commit. flush pulses one cycle. count=0. Writebacks to tags 3–5 are ignored, and the next dispatch receives tag 3.
- With commit_ready=0 and head done, commit_valid holds and head does not move. Releasing commit_ready commits the entry exactly once.
- Assert reset with 4 live entries. Outputs take reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer and its pointer sub-module.
package rob_pkg;

    localparam int FLAG_W     = 4;
    localparam int REG_IDX_W  = 5;
    localparam int ROB_DATA_W = 64;

    // Bit positions inside the 4-bit flag word {negative, zero, overflow, carry_out}
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // One ROB slot; data is sized for the widest supported result and
    // narrower configurations use the low DATA_W bits.
    typedef struct packed {
        logic                  done;
        logic                  mispredict;
        logic [REG_IDX_W-1:0]  rd;
        logic                  reg_write;
        logic                  set_flags;
        logic [ROB_DATA_W-1:0] data;
        logic [FLAG_W-1:0]     flags;
    } rob_entry_t;

    // Assemble a flag word from its individual condition bits.
    function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic z,
                                                     input logic v, input logic c);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping head/tail pointer with a wrap bit in the MSB; load has priority over increment.
module rob_ptr #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             load,
    input  logic [PTR_W-1:0] load_value,
    output logic [PTR_W-1:0] ptr
);

    // Pointer register: a load (flush recovery) overrides a normal advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_value;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order dispatch, out-of-order writeback, in-order
// commit, and flush of all younger work when a mispredicted branch retires.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  DATA_W = 64,
    parameter int  NUM_WB = 2,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [REG_IDX_W-1:0]     disp_rd,
    input  logic                     disp_reg_write,
    input  logic                     disp_set_flags,
    output logic [TAG_W-1:0]         disp_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic [NUM_WB*FLAG_W-1:0] wb_flags,
    input  logic [NUM_WB-1:0]        wb_mispredict,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [REG_IDX_W-1:0]     commit_rd,
    output logic [DATA_W-1:0]        commit_data,
    output logic [FLAG_W-1:0]        commit_flags,
    output logic                     commit_reg_write,
    output logic                     commit_set_flags,
    output logic                     flush,
    output logic [TAG_W:0]           count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W  = TAG_W + 1;
    localparam int PORT_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [PTR_W-1:0]  head_next;
    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    rob_entry_t        entries [DEPTH];
    rob_entry_t        head_entry;
    logic              disp_fire;
    logic              commit_fire;
    logic              mispredict_commit;
    logic              flush_q;
    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  wb_hit;
    logic [DEPTH-1:0]  wb_accept;
    logic [PORT_W-1:0] wb_sel [DEPTH];

    assign head_idx  = head_ptr[TAG_W-1:0];
    assign tail_idx  = tail_ptr[TAG_W-1:0];
    assign head_next = head_ptr + PTR_W'(1);

    assign count = tail_ptr - head_ptr;
    assign empty = (count == '0);
    assign full  = (count == PTR_W'(DEPTH));
    assign flush = flush_q;

    assign disp_ready = !full && !flush_q;
    assign disp_fire  = disp_valid && disp_ready;
    assign disp_tag   = tail_idx;

    assign head_entry        = entries[head_idx];
    assign commit_valid      = !empty && head_entry.done;
    assign commit_fire       = commit_valid && commit_ready;
    assign mispredict_commit = commit_fire && head_entry.mispredict;

    assign commit_rd        = head_entry.rd;
    assign commit_data      = head_entry.data[DATA_W-1:0];
    assign commit_flags     = pack_flags(head_entry.flags[FLAG_N], head_entry.flags[FLAG_Z],
                                         head_entry.flags[FLAG_V], head_entry.flags[FLAG_C]);
    assign commit_reg_write = commit_fire && head_entry.reg_write;
    assign commit_set_flags = commit_fire && head_entry.set_flags;

    // Head advances on commit; a retiring mispredict snaps both pointers past itself.
    rob_ptr #(.PTR_W(PTR_W)) u_head (
        .clk        (clk),
        .reset      (reset),
        .inc        (commit_fire),
        .load       (mispredict_commit),
        .load_value (head_next),
        .ptr        (head_ptr)
    );

    rob_ptr #(.PTR_W(PTR_W)) u_tail (
        .clk        (clk),
        .reset      (reset),
        .inc        (disp_fire),
        .load       (mispredict_commit),
        .load_value (head_next),
        .ptr        (tail_ptr)
    );

    // An entry is live when its distance from head is less than the occupancy.
    always_comb begin
        logic [TAG_W-1:0] offset;
        offset = '0;
        for (int e = 0; e < DEPTH; e++) begin
            offset  = TAG_W'(e) - head_idx;
            live[e] = ({1'b0, offset} < count);
        end
    end

    // Per-entry priority decode: scanning ports high to low lets the lowest port win.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wb_hit[e] = 1'b0;
            wb_sel[e] = '0;
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    wb_hit[e] = 1'b1;
                    wb_sel[e] = PORT_W'(p);
                end
            end
            wb_accept[e] = wb_hit[e] && live[e] && !flush_q
                           && !(disp_fire && (tail_idx == TAG_W'(e)));
        end
    end

    // Entry array: dispatch initialises a slot, writeback completes it, and a
    // retiring mispredict invalidates every completion still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                entries[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (disp_fire && (tail_idx == TAG_W'(e))) begin
                    entries[e].done       <= 1'b0;
                    entries[e].mispredict <= 1'b0;
                    entries[e].rd         <= disp_rd;
                    entries[e].reg_write  <= disp_reg_write;
                    entries[e].set_flags  <= disp_set_flags;
                end else if (wb_accept[e]) begin
                    entries[e].done       <= 1'b1;
                    entries[e].mispredict <= wb_mispredict[wb_sel[e]];
                    entries[e].data       <= ROB_DATA_W'(wb_data[int'(wb_sel[e])*DATA_W +: DATA_W]);
                    entries[e].flags      <= wb_flags[int'(wb_sel[e])*FLAG_W +: FLAG_W];
                end
                if (mispredict_commit) begin
                    entries[e].done <= 1'b0;
                end
            end
        end
    end

    // Flush is a registered one-cycle pulse following a mispredict commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= mispredict_commit;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a scoreboard queue holds expected
// commits in program order and is drained by a commit monitor.
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 64;
    localparam int NUM_WB = 2;
    localparam int TAG_W  = 4;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        sf;
        logic [3:0]  flags;
        logic        mp;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     disp_valid;
    logic                     disp_ready;
    logic [4:0]               disp_rd;
    logic                     disp_reg_write;
    logic                     disp_set_flags;
    logic [TAG_W-1:0]         disp_tag;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic [NUM_WB*4-1:0]      wb_flags;
    logic [NUM_WB-1:0]        wb_mispredict;
    logic                     commit_valid;
    logic                     commit_ready;
    logic [4:0]               commit_rd;
    logic [DATA_W-1:0]        commit_data;
    logic [3:0]               commit_flags;
    logic                     commit_reg_write;
    logic                     commit_set_flags;
    logic                     flush;
    logic [TAG_W:0]           count;
    logic                     empty;
    logic                     full;

    exp_t        sb [$];
    logic [63:0] plannedData [DEPTH];
    logic        plannedMp [DEPTH];
    int          tailModel;
    int          checkCount;
    int          passCount;

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_WB(NUM_WB)) dut (
        .clk              (clk),
        .reset            (reset),
        .disp_valid       (disp_valid),
        .disp_ready       (disp_ready),
        .disp_rd          (disp_rd),
        .disp_reg_write   (disp_reg_write),
        .disp_set_flags   (disp_set_flags),
        .disp_tag         (disp_tag),
        .wb_valid         (wb_valid),
        .wb_tag           (wb_tag),
        .wb_data          (wb_data),
        .wb_flags         (wb_flags),
        .wb_mispredict    (wb_mispredict),
        .commit_valid     (commit_valid),
        .commit_ready     (commit_ready),
        .commit_rd        (commit_rd),
        .commit_data      (commit_data),
        .commit_flags     (commit_flags),
        .commit_reg_write (commit_reg_write),
        .commit_set_flags (commit_set_flags),
        .flush            (flush),
        .count            (count),
        .empty            (empty),
        .full             (full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] flagsFor(input int t);
        logic [3:0] b;
        b = 4'(t);
        return pack_flags(b[0], b[1], b[2] ^ b[0], b[3]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commit monitor: compares every firing commit against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && commit_valid && commit_ready) begin
            checkOutput("sb_avail", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("commit_data", commit_data, e.data);
                checkOutput("commit_rd", 64'(commit_rd), 64'(e.rd));
                checkOutput("commit_flags", 64'(commit_flags), 64'(e.flags));
                checkOutput("commit_reg_write", 64'(commit_reg_write), 64'(e.rw));
                checkOutput("commit_set_flags", 64'(commit_set_flags), 64'(e.sf));
                if (e.mp) begin
                    sb.delete();
                end
            end
        end
    end

    task automatic applyReset();
        disp_valid = 0; disp_rd = 0; disp_reg_write = 0; disp_set_flags = 0;
        wb_valid = 0; wb_tag = 0; wb_data = 0; wb_flags = 0; wb_mispredict = 0;
        commit_ready = 0;
        reset = 0;
        #12;
        reset = 1;
        sb.delete();
        tailModel = 0;
        tick();
    endtask

    task automatic dispatchOne(input logic [63:0] data, input logic mp, input logic rw);
        exp_t e;
        int idx;
        idx = tailModel;
        plannedData[idx] = data;
        plannedMp[idx]   = mp;
        checkOutput("disp_tag", 64'(disp_tag), 64'(idx));
        checkOutput("disp_ready", 64'(disp_ready), 64'(1));
        disp_valid     = 1;
        disp_rd        = 5'(idx + 3);
        disp_reg_write = rw;
        disp_set_flags = ~rw;
        e.data = data; e.rd = 5'(idx + 3); e.rw = rw; e.sf = ~rw; e.flags = flagsFor(idx); e.mp = mp;
        sb.push_back(e);
        tick();
        disp_valid = 0;
        tailModel  = (tailModel + 1) % DEPTH;
    endtask

    task automatic applyStimulus(input logic v0, input int t0, input logic [63:0] d0, input logic mp0,
                                 input logic v1, input int t1, input logic [63:0] d1, input logic mp1);
        wb_valid      = {v1, v0};
        wb_tag        = {4'(t1), 4'(t0)};
        wb_data       = {d1, d0};
        wb_flags      = {flagsFor(t1), flagsFor(t0)};
        wb_mispredict = {mp1, mp0};
        tick();
        wb_valid      = 0;
        wb_mispredict = 0;
    endtask

    task automatic wbTag(input int t);
        applyStimulus(1, t, plannedData[t], plannedMp[t], 0, 0, 64'h0, 0);
    endtask

    task automatic wbPair(input int a, input int b);
        applyStimulus(1, a, plannedData[a], plannedMp[a], 1, b, plannedData[b], plannedMp[b]);
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int i = 0; i < maxCycles && sb.size() > 0; i++) begin
            tick();
        end
        checkOutput("drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        applyReset();

        // Reset state
        checkOutput("rst_disp_ready", 64'(disp_ready), 64'(1));
        checkOutput("rst_disp_tag", 64'(disp_tag), 64'(0));
        checkOutput("rst_commit_valid", 64'(commit_valid), 64'(0));
        checkOutput("rst_flush", 64'(flush), 64'(0));
        checkOutput("rst_count", 64'(count), 64'(0));
        checkOutput("rst_empty", 64'(empty), 64'(1));
        checkOutput("rst_full", 64'(full), 64'(0));

        // Out-of-order writeback, in-order commit
        commit_ready = 1;
        dispatchOne(64'h10, 0, 1);
        dispatchOne(64'h20, 0, 0);
        dispatchOne(64'h30, 0, 1);
        wbTag(2);
        checkOutput("ooo_no_commit", 64'(commit_valid), 64'(0));
        wbTag(0);
        checkOutput("first_commit_valid", 64'(commit_valid), 64'(1));
        checkOutput("first_commit_data", commit_data, 64'h10);
        wbTag(1);
        waitDrain(10);
        checkOutput("ooo_empty", 64'(empty), 64'(1));

        // Fill to full, then wrap
        applyReset();
        for (int i = 0; i < DEPTH; i++) begin
            dispatchOne(64'h100 + 64'(i), 0, ~i[0]);
        end
        checkOutput("full_flag", 64'(full), 64'(1));
        checkOutput("full_ready", 64'(disp_ready), 64'(0));
        checkOutput("full_count", 64'(count), 64'(16));
        disp_valid = 1;
        tick();
        disp_valid = 0;
        checkOutput("full_reject", 64'(count), 64'(16));
        wbTag(0);
        commit_ready = 1;
        #1;
        checkOutput("full_commit_rw", 64'(commit_reg_write), 64'(1));
        tick();
        commit_ready = 0;
        checkOutput("after_commit_full", 64'(full), 64'(0));
        checkOutput("after_commit_count", 64'(count), 64'(15));
        checkOutput("wrap_tag", 64'(disp_tag), 64'(0));
        dispatchOne(64'h200, 0, 1);
        for (int i = 1; i < DEPTH; i += 2) begin
            wbPair(i, (i + 1) % DEPTH);
        end
        commit_ready = 1;
        waitDrain(40);

        // Commit back-pressure and same-cycle writeback collision
        applyReset();
        for (int i = 0; i < 6; i++) begin
            dispatchOne((i == 5) ? 64'hAA : 64'h10 * 64'(i + 1), 0, ~i[0]);
        end
        wbTag(0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_valid", 64'(commit_valid), 64'(1));
            checkOutput("hold_count", 64'(count), 64'(6));
            tick();
        end
        commit_ready = 1;
        #1;
        checkOutput("release_rw", 64'(commit_reg_write), 64'(1));
        tick();
        commit_ready = 0;
        checkOutput("once_count", 64'(count), 64'(5));
        checkOutput("once_valid", 64'(commit_valid), 64'(0));
        applyStimulus(1, 5, 64'hAA, 0, 1, 5, 64'hBB, 0);
        wbPair(1, 2);
        wbPair(3, 4);
        commit_ready = 1;
        waitDrain(20);

        // Mispredict flush
        applyReset();
        commit_ready = 1;
        for (int i = 0; i < 6; i++) begin
            dispatchOne(64'h40 + 64'(i), (i == 2), i[0]);
        end
        wbPair(0, 1);
        wbPair(2, 3);
        wbPair(4, 5);
        for (int i = 0; i < 20 && !flush; i++) begin
            tick();
        end
        checkOutput("flush_seen", 64'(flush), 64'(1));
        checkOutput("flush_count", 64'(count), 64'(0));
        checkOutput("flush_ready", 64'(disp_ready), 64'(0));
        checkOutput("flush_sb", 64'(sb.size()), 64'(0));
        disp_valid = 1;
        applyStimulus(1, 3, 64'hDEAD, 0, 0, 0, 64'h0, 0);
        disp_valid = 0;
        checkOutput("flush_pulse", 64'(flush), 64'(0));
        checkOutput("flush_disp_rej", 64'(count), 64'(0));
        wbPair(4, 5);
        checkOutput("stale_wb_valid", 64'(commit_valid), 64'(0));
        checkOutput("stale_wb_count", 64'(count), 64'(0));
        tailModel = 3;
        dispatchOne(64'h77, 0, 1);
        wbTag(3);
        waitDrain(10);

        // Asynchronous reset with live entries
        applyReset();
        for (int i = 0; i < 4; i++) begin
            dispatchOne(64'h500 + 64'(i), 0, 1);
        end
        wbTag(0);
        checkOutput("pre_rst_valid", 64'(commit_valid), 64'(1));
        checkOutput("pre_rst_count", 64'(count), 64'(4));
        #2;
        reset = 0;
        #1;
        checkOutput("arst_count", 64'(count), 64'(0));
        checkOutput("arst_empty", 64'(empty), 64'(1));
        checkOutput("arst_full", 64'(full), 64'(0));
        checkOutput("arst_commit_valid", 64'(commit_valid), 64'(0));
        checkOutput("arst_disp_tag", 64'(disp_tag), 64'(0));
        checkOutput("arst_disp_ready", 64'(disp_ready), 64'(1));
        checkOutput("arst_flush", 64'(flush), 64'(0));
        sb.delete();
        #3;
        reset = 1;
        tick();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
